// File: rtl/debug_run_controller_if.sv
// Run-controller bundle: UART byte strobe, halt/dump handshakes, and imem/pipeline control outputs.
// The controller uses the master modport; the UART, pipeline and dump side use the slave modport.
interface debug_run_controller_if #(
  parameter int NB_DATA      = 8,
  parameter int NB_INSTR     = 32,
  parameter int NB_IMEM_ADDR = 8
);
  logic [NB_DATA-1:0]      i_rx_data;
  logic                    i_rx_done;
  logic                    i_hlt;
  logic                    i_dump_done;
  logic                    o_cpu_enable;
  logic                    o_pc_clear;
  logic                    o_imem_wr_en;
  logic [NB_IMEM_ADDR-1:0] o_imem_addr;
  logic [NB_INSTR-1:0]     o_imem_data;
  logic                    o_load_done;
  logic                    o_load_err;
  logic                    o_dump_start;
  logic                    o_halted;
  logic [31:0]             o_cycle_count;

  modport master (
    input  i_rx_data, i_rx_done, i_hlt, i_dump_done,
    output o_cpu_enable, o_pc_clear, o_imem_wr_en, o_imem_addr, o_imem_data,
           o_load_done, o_load_err, o_dump_start, o_halted, o_cycle_count
  );

  modport slave (
    output i_rx_data, i_rx_done, i_hlt, i_dump_done,
    input  o_cpu_enable, o_pc_clear, o_imem_wr_en, o_imem_addr, o_imem_data,
           o_load_done, o_load_err, o_dump_start, o_halted, o_cycle_count
  );
endinterface

// File: rtl/debug_run_controller.sv
// UART command sequencer: loads imem, runs or single-steps the pipeline, and hands off to the dump logic on HLT.
// All outputs are registered, one edge after the triggering strobe. There is no backpressure; one byte per cycle is accepted.
// DEBUG_CYCLE_COUNTER_EN adds a saturating enabled-cycle counter; without it, o_cycle_count is tied to 0.
module debug_run_controller #(
  parameter int                   NB_DATA      = 8,
  parameter int                   NB_INSTR     = 32,
  parameter int                   NB_IMEM_ADDR = 8,
  parameter int                   NB_OPCODE    = 6,
  parameter logic [NB_OPCODE-1:0] HLT_OPCODE   = 6'h3f,
  parameter logic [NB_DATA-1:0]   CMD_LOAD     = 8'h4C,
  parameter logic [NB_DATA-1:0]   CMD_RUN      = 8'h43,
  parameter logic [NB_DATA-1:0]   CMD_STEP     = 8'h53,
  parameter logic [NB_DATA-1:0]   CMD_NEXT     = 8'h4E,
  parameter logic [NB_DATA-1:0]   CMD_EXIT     = 8'h45
) (
  input logic                    i_clock,
  input logic                    i_reset,
  debug_run_controller_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, STEP, DONE} state_t;

  localparam logic [NB_IMEM_ADDR-1:0] ADDR_LAST = '1;

  state_t                  state_q, state_d;
  logic [NB_INSTR-1:0]     shift_q, shift_d, word;
  logic [1:0]              byte_cnt_q, byte_cnt_d;
  logic [NB_IMEM_ADDR-1:0] addr_q, addr_d;
  logic [NB_IMEM_ADDR-1:0] wr_addr_q, wr_addr_d;
  logic [NB_INSTR-1:0]     wr_data_q, wr_data_d;
  logic                    wr_en_q, wr_en_d;
  logic                    cpu_enable_q, cpu_enable_d;
  logic                    pc_clear_q, pc_clear_d;
  logic                    load_done_q, load_done_d;
  logic                    load_err_q, load_err_d;
  logic                    dump_start_q, dump_start_d;
  logic                    halted_q, halted_d;
  logic                    cnt_clr;

  // Incoming byte lands in the LSBs so the first byte ends up as the MSB.
  assign word = {shift_q[NB_INSTR-NB_DATA-1:0], bus.i_rx_data};

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      byte_cnt_q   <= '0;
      addr_q       <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
      cpu_enable_q <= 1'b0;
      pc_clear_q   <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
      dump_start_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      byte_cnt_q   <= byte_cnt_d;
      addr_q       <= addr_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      cpu_enable_q <= cpu_enable_d;
      pc_clear_q   <= pc_clear_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
      dump_start_q <= dump_start_d;
      halted_q     <= halted_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    byte_cnt_d   = byte_cnt_q;
    addr_d       = addr_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_en_d      = 1'b0;
    cpu_enable_d = 1'b0;
    pc_clear_d   = 1'b0;
    load_done_d  = 1'b0;
    load_err_d   = load_err_q;
    cnt_clr      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_rx_done) begin
          if (bus.i_rx_data == CMD_LOAD) begin
            state_d    = LOAD;
            addr_d     = '0;
            byte_cnt_d = '0;
            load_err_d = 1'b0;
          end else if (bus.i_rx_data == CMD_RUN) begin
            state_d    = RUN;
            pc_clear_d = 1'b1;
            cnt_clr    = 1'b1;
          end else if (bus.i_rx_data == CMD_STEP) begin
            state_d    = STEP;
            pc_clear_d = 1'b1;
            cnt_clr    = 1'b1;
          end
        end
      end
      LOAD: begin
        if (bus.i_rx_done) begin
          shift_d    = word;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = word;
            if (word[NB_INSTR-1 -: NB_OPCODE] == HLT_OPCODE) begin
              load_done_d = 1'b1;
              state_d     = IDLE;
            end else if (addr_q == ADDR_LAST) begin
              load_err_d = 1'b1;
              state_d    = IDLE;
            end
            // Address saturates at the top word instead of wrapping.
            if (addr_q != ADDR_LAST) addr_d = addr_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.i_hlt) state_d = DONE;
        else           cpu_enable_d = 1'b1;
      end
      STEP: begin
        // A halt wins over a same-cycle NEXT, which is dropped.
        if (bus.i_hlt) begin
          state_d = DONE;
        end else if (bus.i_rx_done) begin
          if (bus.i_rx_data == CMD_NEXT)      cpu_enable_d = 1'b1;
          else if (bus.i_rx_data == CMD_EXIT) state_d = IDLE;
        end
      end
      DONE: begin
        if (bus.i_dump_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    dump_start_d = (state_d == DONE) && (state_q != DONE);
    halted_d     = (state_d == DONE);
  end

  assign bus.o_cpu_enable = cpu_enable_q;
  assign bus.o_pc_clear   = pc_clear_q;
  assign bus.o_imem_wr_en = wr_en_q;
  assign bus.o_imem_addr  = wr_addr_q;
  assign bus.o_imem_data  = wr_data_q;
  assign bus.o_load_done  = load_done_q;
  assign bus.o_load_err   = load_err_q;
  assign bus.o_dump_start = dump_start_q;
  assign bus.o_halted     = halted_q;

`ifdef DEBUG_CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt_q;

  always_ff @(posedge i_clock) begin
    if (!i_reset)                                 cycle_cnt_q <= '0;
    else if (cnt_clr)                             cycle_cnt_q <= '0;
    else if (cpu_enable_q && (cycle_cnt_q != '1)) cycle_cnt_q <= cycle_cnt_q + 32'd1;
  end

  assign bus.o_cycle_count = cycle_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr    = cnt_clr;
  assign bus.o_cycle_count = '0;
`endif
endmodule

// File: tb/tb_debug_run_controller.sv
// Randomized bench for debug_run_controller: checks writes, pulses and counts against expectations derived from the command rules.
module tb_debug_run_controller;
  localparam int AW = 2;
  localparam logic [7:0] C_L = 8'h4C, C_C = 8'h43, C_S = 8'h53, C_N = 8'h4E, C_E = 8'h45;
`ifdef DEBUG_CYCLE_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  debug_run_controller_if #(.NB_IMEM_ADDR(AW)) dif ();
  debug_run_controller #(.NB_IMEM_ADDR(AW)) dut (.i_clock(clk), .i_reset(rst_n), .bus(dif.master));

  int checks = 0;
  int failures = 0;

  // Monitor: observes outputs on the falling edge and accumulates running totals.
  int          wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  int en_cycles = 0, en_rises = 0, dump_pulses = 0, load_done_pulses = 0;
  logic en_prev = 1'b0;

  always @(negedge clk) begin
    if (dif.o_imem_wr_en === 1'b1) begin
      wr_addr_log.push_back(int'(dif.o_imem_addr));
      wr_data_log.push_back(dif.o_imem_data);
    end
    if (dif.o_cpu_enable === 1'b1) en_cycles++;
    if (dif.o_cpu_enable === 1'b1 && en_prev !== 1'b1) en_rises++;
    en_prev = dif.o_cpu_enable;
    if (dif.o_dump_start === 1'b1) dump_pulses++;
    if (dif.o_load_done === 1'b1) load_done_pulses++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    dif.i_rx_data = b;
    dif.i_rx_done = 1'b1;
    tick(1);
    dif.i_rx_done = 1'b0;
    tick(gap);
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 3; i >= 1; i--) send(w[i*8 +: 8], int'($urandom_range(maxgap, 0)));
    send(w[7:0], 0);
    check("wr_timing", dif.o_imem_wr_en, 1);
    tick(int'($urandom_range(maxgap, 0)));
  endtask

  logic [31:0] prog[$];

  // Expected writes: words in order from address 0 up to the first HLT word or the last address.
  task automatic run_load(input int maxgap);
    int  base_wr, base_ld, n_exp;
    bit  stop, done_exp, err_exp;
    base_wr = wr_addr_log.size();
    base_ld = load_done_pulses;
    n_exp = 0; stop = 0; done_exp = 0; err_exp = 0;
    foreach (prog[i]) begin
      if (!stop) begin
        n_exp++;
        if (prog[i][31:26] == 6'h3f) begin done_exp = 1; stop = 1; end
        else if (i == (1 << AW) - 1) begin err_exp = 1; stop = 1; end
      end
    end
    send(C_L, int'($urandom_range(maxgap, 0)));
    check("ld_err_clr", dif.o_load_err, 0);
    for (int i = 0; i < n_exp; i++) send_word(prog[i], maxgap);
    tick(3);
    check("wr_count", wr_addr_log.size() - base_wr, n_exp);
    for (int i = 0; i < n_exp; i++) begin
      if (base_wr + i < wr_addr_log.size()) begin
        check("wr_addr", wr_addr_log[base_wr + i], i);
        check("wr_data", wr_data_log[base_wr + i], prog[i]);
      end
    end
    check("load_done", load_done_pulses - base_ld, done_exp);
    check("load_err", dif.o_load_err, err_exp);
  endtask

  task automatic step_next();
    send(C_N, 0);
    check("step_pulse", dif.o_cpu_enable, 1);
    tick(1);
    check("step_width", dif.o_cpu_enable, 0);
    tick(int'($urandom_range(3, 0)));
  endtask

  task automatic halt_and_dump(input int en_base, input int dump_base, input int n_exp);
    check("halt_en_low", dif.o_cpu_enable, 0);
    check("dump_start", dif.o_dump_start, 1);
    check("halted", dif.o_halted, 1);
    tick(2);
    check("en_cycles", en_cycles - en_base, n_exp);
    check("dump_pulses", dump_pulses - dump_base, 1);
    check("cycle_count", dif.o_cycle_count, CNT_EN ? n_exp : 0);
    dif.i_dump_done = 1'b1;
    tick(1);
    dif.i_dump_done = 1'b0;
    check("halted_clr", dif.o_halted, 0);
    tick(1);
  endtask

  initial begin
    int n, m, h, en_base, rise_base, dump_base, wr_base;
    logic [31:0] w;
    dif.i_rx_data = '0;
    dif.i_rx_done = 1'b0;
    dif.i_hlt = 1'b0;
    dif.i_dump_done = 1'b0;
    tick(3);
    check("rst_ctrl", {dif.o_cpu_enable, dif.o_pc_clear, dif.o_imem_wr_en, dif.o_load_done,
                       dif.o_load_err, dif.o_dump_start, dif.o_halted}, 0);
    check("rst_addr", dif.o_imem_addr, 0);
    check("rst_data", dif.o_imem_data, 0);
    check("rst_count", dif.o_cycle_count, 0);
    rst_n = 1'b1;
    tick(2);

    // Directed load with back-to-back bytes, then random loads with gaps.
    prog = '{32'h20010005, 32'hFC000000};
    run_load(0);
    repeat (6) begin
      n = int'($urandom_range(1 << AW, 1));
      prog = {};
      for (int i = 0; i < n - 1; i++) begin
        w = $urandom;
        if (w[31:26] == 6'h3f) w[31] = 1'b0;
        prog.push_back(w);
      end
      prog.push_back({6'h3f, 26'($urandom)});
      run_load(2);
    end

    // Fill memory without HLT, then extra non-command bytes must not write.
    prog = {};
    for (int i = 0; i < (1 << AW); i++) begin
      w = $urandom;
      w[31] = 1'b0;
      prog.push_back(w);
    end
    run_load(1);
    wr_base = wr_addr_log.size();
    for (int i = 0; i < 4; i++) send(8'h00, 0);
    tick(2);
    check("no_wr_after_err", wr_addr_log.size() - wr_base, 0);
    prog = '{{6'h3f, 26'h0000123}};
    run_load(1);

    // Run until halt after n enabled cycles; a LOAD byte during RUN is ignored.
    for (int r = 0; r < 4; r++) begin
      n = (r == 0) ? 1 : int'($urandom_range(20, 2));
      en_base = en_cycles;
      dump_base = dump_pulses;
      send(C_C, 0);
      check("pc_clear", dif.o_pc_clear, 1);
      check("en_after_clr", dif.o_cpu_enable, 0);
      tick(1);
      check("en_rise", dif.o_cpu_enable, 1);
      check("pc_clear_pulse", dif.o_pc_clear, 0);
      if (n >= 2) send(C_L, n - 2);
      dif.i_hlt = 1'b1;
      tick(1);
      h = int'($urandom_range(2, 0));
      tick(h);
      dif.i_hlt = 1'b0;
      if (h == 0) halt_and_dump(en_base, dump_base, n);
      else begin
        check("halt_en_low", dif.o_cpu_enable, 0);
        check("halted", dif.o_halted, 1);
        halt_and_dump_tail: begin
          tick(1);
          check("en_cycles", en_cycles - en_base, n);
          check("dump_pulses", dump_pulses - dump_base, 1);
          check("cycle_count", dif.o_cycle_count, CNT_EN ? n : 0);
          dif.i_dump_done = 1'b1;
          tick(1);
          dif.i_dump_done = 1'b0;
          check("halted_clr", dif.o_halted, 0);
        end
      end
    end

    // Single-step: m NEXT pulses interleaved with ignored bytes, then EXIT.
    repeat (3) begin
      m = int'($urandom_range(4, 1));
      en_base = en_cycles;
      rise_base = en_rises;
      send(C_S, 2);
      for (int j = 0; j < m; j++) begin
        step_next();
        if ($urandom_range(1, 0) == 1) send(C_C, 1);
      end
      check("step_cycles", en_cycles - en_base, m);
      check("step_rises", en_rises - rise_base, m);
      check("step_count", dif.o_cycle_count, CNT_EN ? m : 0);
      send(C_E, 1);
      check("exit_en_low", dif.o_cpu_enable, 0);
      send(C_N, 2);
      check("idle_ignores_next", en_cycles - en_base, m);
    end

    // HLT and NEXT in the same cycle: no enable pulse, DONE entered.
    m = int'($urandom_range(2, 0));
    en_base = en_cycles;
    dump_base = dump_pulses;
    send(C_S, 1);
    for (int j = 0; j < m; j++) step_next();
    dif.i_hlt = 1'b1;
    dif.i_rx_data = C_N;
    dif.i_rx_done = 1'b1;
    tick(1);
    dif.i_hlt = 1'b0;
    dif.i_rx_done = 1'b0;
    halt_and_dump(en_base, dump_base, m);

    // Reset in the middle of a word: nothing written, next load starts at 0.
    send(C_L, 0);
    send(8'h20, 0);
    send(8'h01, 1);
    wr_base = wr_addr_log.size();
    rst_n = 1'b0;
    tick(1);
    check("midrst_ctrl", {dif.o_cpu_enable, dif.o_pc_clear, dif.o_imem_wr_en, dif.o_load_done,
                          dif.o_load_err, dif.o_dump_start, dif.o_halted}, 0);
    check("midrst_addr_data", {dif.o_imem_addr, dif.o_imem_data}, 0);
    check("midrst_count", dif.o_cycle_count, 0);
    rst_n = 1'b1;
    tick(2);
    check("midrst_no_wr", wr_addr_log.size() - wr_base, 0);
    prog = '{32'h00000011, {6'h3f, 26'h2aaaaaa}};
    run_load(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
